// File: rtl/wb_arbiter_2m_pkg.sv
// Shared definitions for the two-master Wishbone arbiter: FSM states,
// grant encodings, default bus widths and the arbitration decision.
// Imported by wb_arbiter_2m and its watchdog sub-module.
package wb_arbiter_2m_pkg;

  localparam int WB_ADDR_W = 32;
  localparam int WB_DATA_W = 32;

  // One-hot owner indication presented on gnt_o.
  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_OWN0   = 3'd1,
    ST_OWN1   = 3'd2,
    ST_ABORT0 = 3'd3,
    ST_ABORT1 = 3'd4
  } arb_state_t;

  // Choose the next owner from the request lines. last_grant = 1 means m1
  // was served last, so m0 wins a tie (and vice versa).
  function automatic arb_state_t pick_owner(input logic c0, input logic c1,
                                            input logic last_grant);
    if (c0 && c1) return last_grant ? ST_OWN0 : ST_OWN1;
    if (c0)       return ST_OWN0;
    if (c1)       return ST_OWN1;
    return ST_IDLE;
  endfunction

  // Grant vector implied by a state; aborted owners keep their grant.
  function automatic logic [1:0] gnt_of(input arb_state_t st);
    case (st)
      ST_OWN0, ST_ABORT0: return GNT_M0;
      ST_OWN1, ST_ABORT1: return GNT_M1;
      default:            return GNT_NONE;
    endcase
  endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Watchdog counter: counts unacknowledged strobe cycles, flags the threshold.
// Latency: expired is combinational from the count and enable (registered by the user).
// Backpressure: none; clear has priority, count saturates and never wraps.
module wb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] THRESH  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

  logic [CW-1:0] cnt;

  // Count waiting cycles; clear wins, saturate at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != CNT_MAX)) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Threshold reached on a cycle that is still waiting for an ack.
  assign expired = en && (cnt >= THRESH);

endmodule

// File: rtl/wb_arbiter_2m.sv
// Two-master Wishbone classic arbiter with round-robin ties and an ack watchdog.
// Latency: grant 1 cycle after cyc in IDLE; addr/data/ack muxed combinationally once owned.
// Backpressure: owner holds the bus for its whole cyc span; the loser waits with cyc high.
module wb_arbiter_2m
  import wb_arbiter_2m_pkg::*;
#(
  parameter int ADDR_W         = WB_ADDR_W,
  parameter int DATA_W         = WB_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic              m0_we_i,
  input  logic [DATA_W-1:0] m0_data_i,
  input  logic              m0_cyc_i,
  input  logic              m0_stb_i,
  output logic [DATA_W-1:0] m0_data_o,
  output logic              m0_ack_o,
  output logic              m0_err_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic              m1_we_i,
  input  logic [DATA_W-1:0] m1_data_i,
  input  logic              m1_cyc_i,
  input  logic              m1_stb_i,
  output logic [DATA_W-1:0] m1_data_o,
  output logic              m1_ack_o,
  output logic              m1_err_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic              s_we_o,
  output logic [DATA_W-1:0] s_data_o,
  output logic              s_cyc_o,
  output logic              s_stb_o,
  input  logic [DATA_W-1:0] s_data_i,
  input  logic              s_ack_i,
  output logic [1:0]        gnt_o
);

  arb_state_t state;
  logic       last_grant;
  logic [1:0] gnt_q;
  logic       m0_err_q;
  logic       m1_err_q;

  logic       own0;
  logic       own1;
  logic       owner_cyc;
  logic       cnt_clr;
  logic       cnt_en;
  logic       expired;
  arb_state_t next_owner;

  assign own0      = (state == ST_OWN0);
  assign own1      = (state == ST_OWN1);
  assign owner_cyc = own0 ? m0_cyc_i : m1_cyc_i;

  // The releasing master has cyc low, so the same decision serves both
  // IDLE arbitration and same-cycle handover.
  assign next_owner = pick_owner(m0_cyc_i, m1_cyc_i, last_grant);

  // Watchdog restarts outside an active ownership, on every ack and on release,
  // so a fresh owner always starts from zero.
  assign cnt_clr = !(own0 || own1) || s_ack_i || !owner_cyc;
  assign cnt_en  = s_stb_o && !s_ack_i;

  wb_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (sys_clk),
    .rst_n  (sys_rst_n),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired)
  );

  // Slave-side mux: only a live owner drives the slave; IDLE/ABORT force zeros.
  always_comb begin
    s_addr_o = '0;
    s_we_o   = 1'b0;
    s_data_o = '0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    if (own0) begin
      s_addr_o = m0_addr_i;
      s_we_o   = m0_we_i;
      s_data_o = m0_data_i;
      s_cyc_o  = m0_cyc_i;
      s_stb_o  = m0_stb_i;
    end else if (own1) begin
      s_addr_o = m1_addr_i;
      s_we_o   = m1_we_i;
      s_data_o = m1_data_i;
      s_cyc_o  = m1_cyc_i;
      s_stb_o  = m1_stb_i;
    end
  end

  assign m0_data_o = s_data_i;
  assign m1_data_o = s_data_i;
  assign m0_ack_o  = own0 && s_ack_i;
  assign m1_ack_o  = own1 && s_ack_i;
  assign m0_err_o  = m0_err_q;
  assign m1_err_o  = m1_err_q;
  assign gnt_o     = gnt_q;

  // Arbiter FSM with registered grant and one-cycle error pulses.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      gnt_q      <= GNT_NONE;
      m0_err_q   <= 1'b0;
      m1_err_q   <= 1'b0;
    end else begin
      m0_err_q <= 1'b0;
      m1_err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          state <= next_owner;
          gnt_q <= gnt_of(next_owner);
        end
        ST_OWN0, ST_ABORT0: begin
          if (!m0_cyc_i) begin
            last_grant <= 1'b0;
            state      <= next_owner;
            gnt_q      <= gnt_of(next_owner);
          end else if ((state == ST_OWN0) && expired) begin
            state    <= ST_ABORT0;
            m0_err_q <= 1'b1;
          end
        end
        ST_OWN1, ST_ABORT1: begin
          if (!m1_cyc_i) begin
            last_grant <= 1'b1;
            state      <= next_owner;
            gnt_q      <= gnt_of(next_owner);
          end else if ((state == ST_OWN1) && expired) begin
            state    <= ST_ABORT1;
            m1_err_q <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          gnt_q <= GNT_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Directed bench for wb_arbiter_2m: tie, round-robin, single read, timeout, ack-at-threshold, reset.
// Latency: inputs change 2 units after the rising edge; checks sample 1 unit later.
// Backpressure: none; the bench plays both masters and the slave directly.
module tb_wb_arbiter_2m;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic [31:0] m0_addr_i, m1_addr_i, m0_data_i, m1_data_i;
    logic        m0_we_i, m1_we_i, m0_cyc_i, m1_cyc_i, m0_stb_i, m1_stb_i;
    logic [31:0] m0_data_o, m1_data_o;
    logic        m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [31:0] s_addr_o, s_data_o, s_data_i;
    logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
    logic [1:0]  gnt_o;

    int n_cmp = 0;
    int n_err = 0;

    always #5 sys_clk = ~sys_clk;

    wb_arbiter_2m #(
        .ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)
    ) dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
        .m0_addr_i(m0_addr_i), .m0_we_i(m0_we_i), .m0_data_i(m0_data_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_data_o(m0_data_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_addr_i(m1_addr_i), .m1_we_i(m1_we_i), .m1_data_i(m1_data_i),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_data_o(m1_data_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_addr_o(s_addr_o), .s_we_o(s_we_o), .s_data_o(s_data_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_data_i(s_data_i), .s_ack_i(s_ack_i), .gnt_o(gnt_o)
    );

    task automatic tick();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        sys_rst_n = 1'b0;
        m0_addr_i = '0; m1_addr_i = '0; m0_data_i = '0; m1_data_i = '0;
        m0_we_i = 1'b0; m1_we_i = 1'b0;
        m0_cyc_i = 1'b0; m1_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_stb_i = 1'b0;
        s_ack_i = 1'b0; s_data_i = 32'hDEAD_BEEF;
        #1;
        chk("rst_gnt", gnt_o, 2'b00);
        chk("rst_s_cyc", s_cyc_o, 1'b0);
        chk("rst_s_stb", s_stb_o, 1'b0);
        chk("rst_s_addr", s_addr_o, 32'h0);
        chk("rst_m0_ack", m0_ack_o, 1'b0);
        chk("rst_m1_err", m1_err_o, 1'b0);
        chk("rst_m0_data", m0_data_o, 32'hDEAD_BEEF);
        chk("rst_m1_data", m1_data_o, 32'hDEAD_BEEF);
        tick();
        sys_rst_n = 1'b1;

        tick();
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b1;
        m0_addr_i = 32'h10; m0_data_i = 32'hA0;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_we_i = 1'b0;
        m1_addr_i = 32'h20; m1_data_i = 32'hB1;
        #1;
        chk("tie_idle_gnt", gnt_o, 2'b00);
        chk("tie_idle_s_cyc", s_cyc_o, 1'b0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("tie_gnt_m0", gnt_o, 2'b01);
        chk("tie_s_addr", s_addr_o, 32'h10);
        chk("tie_s_we", s_we_o, 1'b1);
        chk("tie_s_data", s_data_o, 32'hA0);
        chk("tie_m0_ack", m0_ack_o, 1'b1);
        chk("tie_m1_ack", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        #1;
        chk("tie_rel_gnt", gnt_o, 2'b01);
        chk("tie_rel_s_cyc", s_cyc_o, 1'b0);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("tie_gnt_m1", gnt_o, 2'b10);
        chk("tie_m1_s_cyc", s_cyc_o, 1'b1);
        chk("tie_m1_s_addr", s_addr_o, 32'h20);
        chk("tie_m1_ack", m1_ack_o, 1'b1);
        chk("tie_m0_noack", m0_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0;
        tick();
        #1;
        chk("tie_end_idle", gnt_o, 2'b00);

        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int i = 0; i < 8; i++) begin
            s_ack_i = 1'b1; s_data_i = 32'(i + 100);
            #1;
            if (i % 2 == 0) begin
                chk("rr_gnt_m0", gnt_o, 2'b01);
                chk("rr_owner_ack_m0", m0_ack_o, 1'b1);
                chk("rr_other_ack_m1", m1_ack_o, 1'b0);
                chk("rr_data_m0", m0_data_o, 32'(i + 100));
            end else begin
                chk("rr_gnt_m1", gnt_o, 2'b10);
                chk("rr_owner_ack_m1", m1_ack_o, 1'b1);
                chk("rr_other_ack_m0", m0_ack_o, 1'b0);
                chk("rr_data_m1", m1_data_o, 32'(i + 100));
            end
            tick();
            s_ack_i = 1'b0;
            if (i % 2 == 0) begin m0_cyc_i = 1'b0; m0_stb_i = 1'b0; end
            else            begin m1_cyc_i = 1'b0; m1_stb_i = 1'b0; end
            tick();
            if (i < 7) begin
                if (i % 2 == 0) begin m0_cyc_i = 1'b1; m0_stb_i = 1'b1; end
                else            begin m1_cyc_i = 1'b1; m1_stb_i = 1'b1; end
            end
        end
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        #1;
        chk("rr_end_idle", gnt_o, 2'b00);

        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h44;
        tick();
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("to_wait_err", m1_err_o, 1'b0);
            chk("to_wait_s_cyc", s_cyc_o, 1'b1);
            tick();
        end
        #1;
        chk("to_err_pulse", m1_err_o, 1'b1);
        chk("to_m0_err", m0_err_o, 1'b0);
        chk("to_s_cyc_drop", s_cyc_o, 1'b0);
        chk("to_s_stb_drop", s_stb_o, 1'b0);
        chk("to_gnt_held", gnt_o, 2'b10);
        tick();
        s_ack_i = 1'b1;
        #1;
        chk("to_err_once", m1_err_o, 1'b0);
        chk("to_gnt_abort", gnt_o, 2'b10);
        chk("to_ack_ignored", m1_ack_o, 1'b0);
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        #1;
        chk("to_release_idle", gnt_o, 2'b00);

        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick();
        for (int k = 0; k < 15; k++) tick();
        s_ack_i = 1'b1; s_data_i = 32'h77;
        #1;
        chk("thr_ack", m1_ack_o, 1'b1);
        chk("thr_data", m1_data_o, 32'h77);
        tick();
        s_ack_i = 1'b0;
        #1;
        chk("thr_no_err", m1_err_o, 1'b0);
        chk("thr_still_own", gnt_o, 2'b10);
        chk("thr_s_cyc", s_cyc_o, 1'b1);
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        #1;
        chk("thr_end_idle", gnt_o, 2'b00);

        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_addr_i = 32'h0;
        tick();
        #1;
        chk("single_gnt", gnt_o, 2'b01);
        chk("single_s_stb", s_stb_o, 1'b1);
        chk("single_s_addr", s_addr_o, 32'h0);
        chk("single_wait_ack", m0_ack_o, 1'b0);
        tick();
        tick();
        s_ack_i = 1'b1; s_data_i = 32'h0000_0041;
        #1;
        chk("single_ack", m0_ack_o, 1'b1);
        chk("single_data", m0_data_o, 32'h41);
        chk("single_m1_ack", m1_ack_o, 1'b0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        #1;
        chk("single_end_idle", gnt_o, 2'b00);

        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        #1;
        chk("mr_pre_gnt", gnt_o, 2'b01);
        chk("mr_pre_s_stb", s_stb_o, 1'b1);
        sys_rst_n = 1'b0;
        #1;
        chk("mr_s_cyc", s_cyc_o, 1'b0);
        chk("mr_s_stb", s_stb_o, 1'b0);
        chk("mr_gnt", gnt_o, 2'b00);
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_addr_i = 32'h20;
        tick();
        sys_rst_n = 1'b1;
        #1;
        chk("mr_rel_idle", gnt_o, 2'b00);
        tick();
        #1;
        chk("mr_tie_m0", gnt_o, 2'b01);
        chk("mr_tie_addr", s_addr_o, 32'h0);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
